// File: rtl/run_controller.sv
// run_controller: sequences one test run of an attached processor.
// It clears data memory, accepts a preload stream, releases the processor,
// waits for its done flag, then streams a block of result words out.
//
// Optional feature macro: RUN_CTRL_TIMEOUT_EN
//   defined   -> RUN is abandoned after TIMEOUT_CYC cycles, sticky timeout flag set
//   undefined -> RUN waits for dut_done indefinitely, timeout tied low
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for go; processor held in start/hold
// S_CLEAR    | writing zero to addresses 0..DEPTH-1, one per cycle
// S_PRELOAD  | accepting preload beats, each written in its accept cycle
// S_LAUNCH   | single cycle with processor still held, start falls after it
// S_RUN      | processor running; cycle counter advancing
// S_DUMP_RD  | result address presented to memory
// S_DUMP_OUT | first cycle captures read data, then holds it until accepted
module run_controller #(
  parameter int DW          = 8,
  parameter int AW          = 8,
  parameter int DEPTH       = 256,
  parameter int RES_BASE    = 5,
  parameter int RES_COUNT   = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          go,
  output logic          busy,
  input  logic          pl_valid,
  output logic          pl_ready,
  input  logic [AW-1:0] pl_addr,
  input  logic [DW-1:0] pl_data,
  input  logic          pl_last,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          dut_start,
  input  logic          dut_done,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          res_last,
  output logic          timeout,
  output logic [31:0]   cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_PRELOAD,
    S_LAUNCH,
    S_RUN,
    S_DUMP_RD,
    S_DUMP_OUT
  } state_t;

  localparam logic [AW-1:0] CLR_LAST  = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_LIM = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] BASE_ADDR = AW'(RES_BASE);
  localparam logic [31:0]   RES_CNT   = 32'(RES_COUNT);
  localparam logic [31:0]   TO_LIM    = 32'(TIMEOUT_CYC);

  // Reject parameter sets the address counter and timeout compare cannot honour.
  if (DEPTH < 1 || DEPTH > (1 << AW) || RES_COUNT < 0 || TIMEOUT_CYC < 1) begin : g_param_chk
    $error("run_controller: illegal DEPTH/RES_COUNT/TIMEOUT_CYC for AW");
  end

  state_t        state_q, state_d;
  logic [AW-1:0] clr_addr_q;
  logic [31:0]   idx_q;
  logic [31:0]   cycles_q;
  logic          res_vld_q;
  logic          res_last_q;
  logic [DW-1:0] res_data_q;

  logic          pl_in_range;
  logic [31:0]   cyc_inc;
  logic [31:0]   idx_next;
  logic          more_res;
  logic          to_hit;
  logic          run_exit;

  assign pl_in_range = ({1'b0, pl_addr} < DEPTH_LIM);
  assign cyc_inc     = (&cycles_q) ? cycles_q : cycles_q + 32'd1;
  assign idx_next    = idx_q + 32'd1;
  assign more_res    = (idx_next < RES_CNT);

`ifdef RUN_CTRL_TIMEOUT_EN
  // cyc_inc is the value cycles takes at the end of this cycle, so the
  // run ends on the cycle in which the count reaches the limit.
  assign to_hit = (cyc_inc >= TO_LIM);
`else
  assign to_hit = 1'b0;
`endif

  assign run_exit = dut_done | to_hit;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (go) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        if (clr_addr_q == CLR_LAST) state_d = S_PRELOAD;
      end
      S_PRELOAD: begin
        if (pl_valid && pl_last) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (run_exit) state_d = (RES_CNT == 32'd0) ? S_IDLE : S_DUMP_RD;
      end
      S_DUMP_RD: begin
        state_d = S_DUMP_OUT;
      end
      S_DUMP_OUT: begin
        if (res_vld_q && res_ready) state_d = more_res ? S_DUMP_RD : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode; everything here follows state_q so reset acts at once.
  always_comb begin
    busy      = 1'b1;
    pl_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    dut_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy      = 1'b0;
        dut_start = 1'b1;
      end
      S_CLEAR: begin
        dut_start = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = clr_addr_q;
      end
      S_PRELOAD: begin
        dut_start = 1'b1;
        pl_ready  = 1'b1;
        if (pl_valid) begin
          // Out-of-range beats are still accepted so the stream keeps moving.
          mem_we    = pl_in_range;
          mem_addr  = pl_addr;
          mem_wdata = pl_data;
        end
      end
      S_LAUNCH: begin
        dut_start = 1'b1;
      end
      S_DUMP_RD, S_DUMP_OUT: begin
        mem_addr = BASE_ADDR + idx_q[AW-1:0];
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // Clear address, result index, run cycle counter and result holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_addr_q <= '0;
      idx_q      <= '0;
      cycles_q   <= '0;
      res_vld_q  <= 1'b0;
      res_last_q <= 1'b0;
      res_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          clr_addr_q <= '0;
        end
        S_CLEAR: begin
          clr_addr_q <= clr_addr_q + 1'b1;
        end
        S_LAUNCH: begin
          cycles_q <= '0;
        end
        S_RUN: begin
          cycles_q <= cyc_inc;
          idx_q    <= '0;
        end
        S_DUMP_OUT: begin
          if (!res_vld_q) begin
            // Read data for the address presented in DUMP_RD is valid now.
            res_data_q <= mem_rdata;
            res_last_q <= (idx_next == RES_CNT);
            res_vld_q  <= 1'b1;
          end else if (res_ready) begin
            res_vld_q <= 1'b0;
            idx_q     <= idx_next;
          end
        end
        default: begin
          clr_addr_q <= clr_addr_q;
        end
      endcase
    end
  end

  assign res_valid = res_vld_q;
  assign res_data  = res_data_q;
  assign res_last  = res_vld_q & res_last_q;
  assign cycles    = cycles_q;

`ifdef RUN_CTRL_TIMEOUT_EN
  logic timeout_q;

  // Sticky timeout flag: set when RUN gives up, cleared only by a new launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else if (state_q == S_IDLE && go) begin
      timeout_q <= 1'b0;
    end else if (state_q == S_RUN && !dut_done && to_hit) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 Parameter DW, 8, memory word width in bits.
REQ-002 Parameter AW, 8, memory address width in bits.
REQ-003 Parameter DEPTH, 256, number of data-memory words to clear (DEPTH <= 2**AW).
REQ-004 Parameter RES_BASE, 5, first result address read back after the run.
REQ-005 Parameter RES_COUNT, 4, number of result words streamed out (0 allowed).
REQ-006 Parameter TIMEOUT_CYC, 100000, RUN-cycle limit (used only under RUN_CTRL_TIMEOUT_EN).
REQ-007 CLK  in  1  single clock, all state updates on rising edge.
REQ-008 RST_N  in  1  reset, asynchronous, active-low.
REQ-009 GO  in  1  launch request, sampled in IDLE only.
REQ-010 BUSY  out  1  high in every state except IDLE.
REQ-011 PL_VALID  in  1  preload beat valid.
REQ-012 PL_READY  out  1  preload beat accepted when PL_VALID and PL_READY both high.
REQ-013 PL_ADDR  in  AW  preload target address.
REQ-014 PL_DATA  in  DW  preload value.
REQ-015 PL_LAST  in  1  marks final preload beat.
REQ-016 MEM_WE  out  1  data-memory write enable.
REQ-017 MEM_ADDR  out  AW  data-memory address (write and read).
REQ-018 MEM_WDATA  out  DW  data-memory write data.
REQ-019 MEM_RDATA  in  DW  data-memory read data, valid one cycle after MEM_ADDR.
REQ-020 DUT_START  out  1  processor start/hold; high holds processor, falling edge launches program.
REQ-021 DUT_DONE  in  1  processor done flag.
REQ-022 RES_VALID  out  1  result word valid.
REQ-023 RES_READY  in  1  result consumer ready.
REQ-024 RES_DATA  out  DW  result word.
REQ-025 RES_LAST  out  1  high with the final result word.
REQ-026 TIMEOUT  out  1  sticky run-timeout flag.
REQ-027 CYCLES  out  32  RUN-state cycle count of the last run.

Function
REQ-028 FSM states IDLE, CLEAR, PRELOAD, LAUNCH, RUN, DUMP_RD, DUMP_OUT; IDLE->CLEAR on GO (GO ignored when BUSY); GO also clears TIMEOUT.
REQ-029 CLEAR: MEM_WE=1, MEM_WDATA=0, MEM_ADDR 0..DEPTH-1 one per cycle (DEPTH cycles), then PRELOAD.
REQ-030 PRELOAD: PL_READY=1; each accepted beat writes PL_DATA to PL_ADDR in the same cycle; PL_ADDR >= DEPTH accepted, no write; accepted beat with PL_LAST -> LAUNCH.
REQ-031 DUT_START=1 in IDLE, CLEAR, PRELOAD, LAUNCH; LAUNCH lasts exactly 1 cycle; DUT_START=0 in RUN, DUMP_RD, DUMP_OUT.
REQ-032 RUN: CYCLES cleared on entry, +1 per RUN cycle including the exit cycle, saturating at 32'hFFFFFFFF; DUT_DONE sampled from first RUN cycle; DUT_DONE=1 -> DUMP_RD (or IDLE if RES_COUNT=0).
REQ-033 DUMP_RD drives MEM_ADDR=RES_BASE+i (i = 0..RES_COUNT-1, modulo 2**AW wrap) with MEM_WE=0; next cycle DUMP_OUT registers MEM_RDATA to RES_DATA, RES_VALID=1.
REQ-034 RES_VALID/RES_DATA/RES_LAST held stable until RES_READY; on handshake i+1 < RES_COUNT -> DUMP_RD, else -> IDLE; RES_LAST=1 only for i=RES_COUNT-1.
REQ-035 MEM_WE=0 in every state other than CLEAR and accepted PRELOAD beats.

Reset
REQ-036 RST_N low at any time (mid-operation included) forces IDLE immediately: BUSY=0, PL_READY=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, DUT_START=1, RES_VALID=0, RES_DATA=0, RES_LAST=0, TIMEOUT=0, CYCLES=0.
REQ-037 After RST_N rises, no state change until GO sampled high.

Configuration
REQ-038 RUN_CTRL_TIMEOUT_EN defined: CYCLES reaching TIMEOUT_CYC in RUN without DUT_DONE sets TIMEOUT=1 and proceeds to DUMP_RD (results still streamed); simultaneous DUT_DONE wins, TIMEOUT stays 0.
REQ-039 RUN_CTRL_TIMEOUT_EN undefined: RUN waits indefinitely for DUT_DONE; TIMEOUT tied 0.

Verification
REQ-040 Reset, GO, preload {0:85,1:5,60:240,68:255 LAST}, DUT_DONE high 50 cycles after LAUNCH -> memory 0..255 zero except preloads, CYCLES=50, DUT_START falls exactly 1 cycle after last beat.
REQ-041 Memory 5..8 = {3,7,9,1}, RES_READY toggling 1/0 -> stream 3,7,9,1, RES_LAST only on 1, data stable while stalled.
REQ-042 Preload beat PL_ADDR=8'hFF with DEPTH=200 -> no write, accepted, FSM advances normally.
REQ-043 RST_N pulsed low mid-CLEAR (address 100) -> IDLE, DUT_START=1, BUSY=0 same cycle; fresh GO restarts clear at 0.
REQ-044 Macro defined, TIMEOUT_CYC=20, DUT_DONE never -> TIMEOUT=1, CYCLES=20, 4 words streamed; next GO clears TIMEOUT.
REQ-045 RES_COUNT=0, DUT_DONE already high at first RUN cycle -> CYCLES=1, return to IDLE next cycle, no RES_VALID.
